// File: rtl/pc_unit_pkg.sv
// Shared encodings for the program-counter stage: PCSrc selects, sequencer
// states and the default reset vector.
package pc_unit_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_J   = 2'b10,
        PCSRC_JR  = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_FETCHED = 2'b01,
        S_DECODED = 2'b10
    } pc_state_e;

    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_3000;

endpackage

// File: rtl/pc_unit_if.sv
// Control/data bundle between the multicycle controller and pc_unit.
// BranchCount/TakenCount exist only when BRANCH_STATS_EN is defined.
interface pc_unit_if;

    logic        FetchEn;
    logic        DecodeEn;
    logic        ResolveEn;
    logic [1:0]  PCSrc;
    logic [31:0] Instr;
    logic        BranchSucceed;
    logic [31:0] RegA;
    logic [31:0] PC;
    logic [31:0] InstrAddr;
    logic [31:0] BranchTarget;
    logic        Redirect;
    logic        SeqError;
`ifdef BRANCH_STATS_EN
    logic [31:0] BranchCount;
    logic [31:0] TakenCount;
`endif

    modport master (
        output FetchEn, DecodeEn, ResolveEn, PCSrc, Instr, BranchSucceed, RegA,
        input  PC, InstrAddr, BranchTarget, Redirect, SeqError
`ifdef BRANCH_STATS_EN
        , input BranchCount, TakenCount
`endif
    );

    modport slave (
        input  FetchEn, DecodeEn, ResolveEn, PCSrc, Instr, BranchSucceed, RegA,
        output PC, InstrAddr, BranchTarget, Redirect, SeqError
`ifdef BRANCH_STATS_EN
        , output BranchCount, TakenCount
`endif
    );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational branch/jump target computation from the post-fetch PC
// (InstrAddr+4) and the current instruction.
module pc_target_calc (
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic [31:0] o_branch_target,
    output logic [31:0] o_jump_target
);

    logic [31:0] w_br_offset;

    assign w_br_offset     = {{14{i_instr[15]}}, i_instr[15:0], 2'b00};
    assign o_branch_target = i_pc + w_br_offset;
    assign o_jump_target   = {i_pc[31:28], i_instr[25:0], 2'b00};

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: fetch/decode/resolve sequencer with PC commit.
// Optional branch statistics counters enabled by BRANCH_STATS_EN.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR
) (
    input  logic      clk,
    input  logic      rst,
    pc_unit_if.slave  bus
);

    pc_state_e   r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr_addr;
    logic [31:0] r_branch_target;
    logic [31:0] r_jump_target;
    logic        r_redirect;
    logic        r_seq_error;
`ifdef BRANCH_STATS_EN
    logic [31:0] r_branch_count;
    logic [31:0] r_taken_count;
`endif

    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic        w_any_strobe;
    logic        w_multi_strobe;
    pcsrc_e      w_pcsrc;

    pc_target_calc u_target_calc (
        .i_pc            (r_pc),
        .i_instr         (bus.Instr),
        .o_branch_target (w_branch_target),
        .o_jump_target   (w_jump_target)
    );

    assign w_any_strobe   = bus.FetchEn | bus.DecodeEn | bus.ResolveEn;
    assign w_multi_strobe = (bus.FetchEn & bus.DecodeEn) |
                            (bus.FetchEn & bus.ResolveEn) |
                            (bus.DecodeEn & bus.ResolveEn);
    assign w_pcsrc        = pcsrc_e'(bus.PCSrc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_pc            <= RESET_VECTOR;
            r_instr_addr    <= RESET_VECTOR;
            r_branch_target <= '0;
            r_jump_target   <= '0;
            r_redirect      <= 1'b0;
            r_seq_error     <= 1'b0;
`ifdef BRANCH_STATS_EN
            r_branch_count  <= '0;
            r_taken_count   <= '0;
`endif
        end else begin
            r_redirect  <= 1'b0;
            r_seq_error <= 1'b0;
            // A strobe is accepted only if it is the sole strobe and matches the state.
            if (w_multi_strobe) begin
                r_seq_error <= 1'b1;
            end else if (w_any_strobe) begin
                unique case (r_state)
                    S_IDLE: begin
                        if (bus.FetchEn) begin
                            r_instr_addr <= r_pc;
                            r_pc         <= r_pc + 32'd4;
                            r_state      <= S_FETCHED;
                        end else begin
                            r_seq_error  <= 1'b1;
                        end
                    end
                    S_FETCHED: begin
                        if (bus.DecodeEn) begin
                            r_branch_target <= w_branch_target;
                            r_jump_target   <= w_jump_target;
                            r_state         <= S_DECODED;
                        end else begin
                            r_seq_error     <= 1'b1;
                        end
                    end
                    S_DECODED: begin
                        if (bus.ResolveEn) begin
                            r_state <= S_IDLE;
                            unique case (w_pcsrc)
                                PCSRC_SEQ: ;
                                PCSRC_BR: begin
                                    if (bus.BranchSucceed) begin
                                        r_pc       <= r_branch_target;
                                        r_redirect <= 1'b1;
                                    end
`ifdef BRANCH_STATS_EN
                                    r_branch_count <= r_branch_count + 32'd1;
                                    if (bus.BranchSucceed)
                                        r_taken_count <= r_taken_count + 32'd1;
`endif
                                end
                                PCSRC_J: begin
                                    r_pc       <= r_jump_target;
                                    r_redirect <= 1'b1;
                                end
                                PCSRC_JR: begin
                                    r_pc       <= {bus.RegA[31:2], 2'b00};
                                    r_redirect <= 1'b1;
                                end
                                default: ;
                            endcase
                        end else begin
                            r_seq_error <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.PC           = r_pc;
    assign bus.InstrAddr    = r_instr_addr;
    assign bus.BranchTarget = r_branch_target;
    assign bus.Redirect     = r_redirect;
    assign bus.SeqError     = r_seq_error;
`ifdef BRANCH_STATS_EN
    assign bus.BranchCount  = r_branch_count;
    assign bus.TakenCount   = r_taken_count;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; counter checks are compiled
// in only when BRANCH_STATS_EN is defined.
module tb_pc_unit;

    logic clk = 1'b0;
    logic rst;
    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    pc_unit_if bus ();

    pc_unit #(.RESET_VECTOR(32'h0000_3000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply the given strobes for one posedge, then release them; returns at posedge+1.
    task automatic strobe(input logic f, input logic d, input logic r);
        bus.FetchEn   = f;
        bus.DecodeEn  = d;
        bus.ResolveEn = r;
        @(posedge clk);
        #1;
        bus.FetchEn   = 1'b0;
        bus.DecodeEn  = 1'b0;
        bus.ResolveEn = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    // Full instruction that jumps the PC to an arbitrary aligned address via JR.
    task automatic jr_to(input logic [31:0] addr);
        strobe(1, 0, 0);
        bus.Instr = 32'h0;
        strobe(0, 1, 0);
        bus.PCSrc = 2'b11;
        bus.RegA  = addr;
        strobe(0, 0, 1);
    endtask

    initial begin
        rst               = 1'b1;
        bus.FetchEn       = 1'b0;
        bus.DecodeEn      = 1'b0;
        bus.ResolveEn     = 1'b0;
        bus.PCSrc         = 2'b00;
        bus.Instr         = 32'h0;
        bus.BranchSucceed = 1'b0;
        bus.RegA          = 32'h0;

        do_reset();
        check("rst_pc",    bus.PC,           32'h0000_3000);
        check("rst_ia",    bus.InstrAddr,    32'h0000_3000);
        check("rst_bt",    bus.BranchTarget, 32'h0);
        check("rst_redir", {31'b0, bus.Redirect}, 32'h0);
        check("rst_serr",  {31'b0, bus.SeqError}, 32'h0);
`ifdef BRANCH_STATS_EN
        check("rst_bcnt",  bus.BranchCount, 32'h0);
        check("rst_tcnt",  bus.TakenCount,  32'h0);
`endif

        strobe(1, 0, 0);
        check("fetch_pc", bus.PC,        32'h0000_3004);
        check("fetch_ia", bus.InstrAddr, 32'h0000_3000);
        bus.Instr = 32'h0;
        strobe(0, 1, 0);
        bus.PCSrc = 2'b11;
        bus.RegA  = 32'h0000_3010;
        strobe(0, 0, 1);
        check("jr_setup_pc",    bus.PC, 32'h0000_3010);
        check("jr_setup_redir", {31'b0, bus.Redirect}, 32'h1);

        // Taken backward branch
        strobe(1, 0, 0);
        check("tb_fetch_redir_clear", {31'b0, bus.Redirect}, 32'h0);
        check("tb_fetch_pc", bus.PC,        32'h0000_3014);
        check("tb_fetch_ia", bus.InstrAddr, 32'h0000_3010);
        bus.Instr = 32'h0000_FFFC;
        strobe(0, 1, 0);
        check("tb_bt", bus.BranchTarget, 32'h0000_3004);
        bus.PCSrc         = 2'b01;
        bus.BranchSucceed = 1'b1;
        strobe(0, 0, 1);
        check("tb_pc",    bus.PC, 32'h0000_3004);
        check("tb_redir", {31'b0, bus.Redirect}, 32'h1);
`ifdef BRANCH_STATS_EN
        check("tb_bcnt", bus.BranchCount, 32'h1);
        check("tb_tcnt", bus.TakenCount,  32'h1);
`endif
        @(posedge clk); #1;
        check("tb_redir_once", {31'b0, bus.Redirect}, 32'h0);
        check("idle_hold_pc",  bus.PC, 32'h0000_3004);

        // Not-taken branch from a fresh reset
        do_reset();
        jr_to(32'h0000_3010);
        strobe(1, 0, 0);
        bus.Instr = 32'h0000_FFFC;
        strobe(0, 1, 0);
        bus.PCSrc         = 2'b01;
        bus.BranchSucceed = 1'b0;
        strobe(0, 0, 1);
        check("nt_pc",    bus.PC, 32'h0000_3014);
        check("nt_redir", {31'b0, bus.Redirect}, 32'h0);
`ifdef BRANCH_STATS_EN
        check("nt_bcnt", bus.BranchCount, 32'h1);
        check("nt_tcnt", bus.TakenCount,  32'h0);
`endif

        // J
        strobe(1, 0, 0);
        check("j_fetch_pc", bus.PC, 32'h0000_3018);
        bus.Instr = 32'h0800_0100;
        strobe(0, 1, 0);
        bus.PCSrc = 2'b10;
        strobe(0, 0, 1);
        check("j_pc",    bus.PC, 32'h0000_0400);
        check("j_redir", {31'b0, bus.Redirect}, 32'h1);

        // JR with misaligned register value
        strobe(1, 0, 0);
        check("jr_fetch_ia", bus.InstrAddr, 32'h0000_0400);
        strobe(0, 1, 0);
        bus.PCSrc = 2'b11;
        bus.RegA  = 32'h0000_3023;
        strobe(0, 0, 1);
        check("jr_pc", bus.PC, 32'h0000_3020);

        // Sequential resolve keeps the post-fetch PC
        strobe(1, 0, 0);
        strobe(0, 1, 0);
        bus.PCSrc = 2'b00;
        strobe(0, 0, 1);
        check("seq_pc",    bus.PC, 32'h0000_3024);
        check("seq_redir", {31'b0, bus.Redirect}, 32'h0);

        // Decode strobe while idle
        strobe(0, 1, 0);
        check("perr_dec_serr", {31'b0, bus.SeqError}, 32'h1);
        check("perr_dec_pc",   bus.PC, 32'h0000_3024);
        @(posedge clk); #1;
        check("perr_serr_once", {31'b0, bus.SeqError}, 32'h0);
        strobe(0, 0, 1);
        check("perr_res_serr", {31'b0, bus.SeqError}, 32'h1);

        // Fetch+Resolve together in S_DECODED, then a lone resolve still works
        strobe(1, 0, 0);
        check("perr2_fetch_serr", {31'b0, bus.SeqError}, 32'h0);
        check("perr2_fetch_pc",   bus.PC, 32'h0000_3028);
        bus.Instr = 32'h0000_0002;
        strobe(0, 1, 0);
        check("perr2_bt", bus.BranchTarget, 32'h0000_3030);
        bus.PCSrc         = 2'b01;
        bus.BranchSucceed = 1'b1;
        strobe(1, 0, 1);
        check("perr2_serr", {31'b0, bus.SeqError}, 32'h1);
        check("perr2_pc",   bus.PC, 32'h0000_3028);
        check("perr2_ia",   bus.InstrAddr, 32'h0000_3024);
        strobe(0, 0, 1);
        check("perr2_resolve_pc", bus.PC, 32'h0000_3030);
        check("perr2_redir",      {31'b0, bus.Redirect}, 32'h1);

        // Wrap at the top of the address space
        jr_to(32'hFFFF_FFFC);
        strobe(1, 0, 0);
        check("wrap_pc", bus.PC,        32'h0000_0000);
        check("wrap_ia", bus.InstrAddr, 32'hFFFF_FFFC);
        bus.Instr = 32'h0000_FFFF;
        strobe(0, 1, 0);
        check("wrap_bt", bus.BranchTarget, 32'hFFFF_FFFC);

        // Reset while in S_DECODED with resolve asserted
        bus.PCSrc     = 2'b10;
        bus.ResolveEn = 1'b1;
        rst           = 1'b1;
        @(posedge clk); #1;
        bus.ResolveEn = 1'b0;
        rst           = 1'b0;
        check("mrst_pc",    bus.PC,           32'h0000_3000);
        check("mrst_ia",    bus.InstrAddr,    32'h0000_3000);
        check("mrst_bt",    bus.BranchTarget, 32'h0);
        check("mrst_redir", {31'b0, bus.Redirect}, 32'h0);
`ifdef BRANCH_STATS_EN
        check("mrst_bcnt", bus.BranchCount, 32'h0);
        check("mrst_tcnt", bus.TakenCount,  32'h0);
`endif
        strobe(1, 0, 0);
        check("mrst_fetch_serr", {31'b0, bus.SeqError}, 32'h0);
        check("mrst_fetch_pc",   bus.PC, 32'h0000_3004);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter stage of the multicycle MIPS datapath, directly downstream of the branch-condition unit. Holds the PC, advances it at fetch, and computes branch/jump targets at decode. At resolve it commits the next PC, using the branch unit's `BranchSucceed` for conditional branches. A three-state sequencer enforces the fetch → decode → resolve order and flags protocol errors from the control FSM.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'h0000_3000: PC value after reset.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `FetchEn`  in  1  fetch strobe from control.
- `DecodeEn`  in  1  decode strobe from control.
- `ResolveEn`  in  1  resolve strobe from control.
- `PCSrc`  in  2  next-PC select at resolve: 00 sequential, 01 conditional branch, 10 J/JAL, 11 JR.
- `Instr`  in  32  current instruction, sampled at decode.
- `BranchSucceed`  in  1  branch-unit result, sampled at resolve.
- `RegA`  in  32  rs register value (JR target), sampled at resolve.
- `PC`  out  32  current program counter.
- `InstrAddr`  out  32  address of the instruction being executed.
- `BranchTarget`  out  32  registered branch target.
- `Redirect`  out  1  one-cycle pulse after a non-sequential PC commit.
- `SeqError`  out  1  one-cycle pulse after a rejected strobe.
- `BranchCount`, `TakenCount`  out  32 each; present only under `BRANCH_STATS_EN`.

## Operation
- States: S_IDLE, S_FETCHED, S_DECODED. Reset state is S_IDLE.
- S_IDLE + `FetchEn`: `InstrAddr` <= `PC`, `PC` <= `PC`+4, go to S_FETCHED.
- S_FETCHED + `DecodeEn`: latch the targets, go to S_DECODED.
  - `BranchTarget` <= `PC` + {{14{Instr[15]}}, Instr[15:0], 2'b00}.
  - JumpTarget (internal) <= {PC[31:28], Instr[25:0], 2'b00}.
  - `PC` at this point is `InstrAddr`+4.
- S_DECODED + `ResolveEn`: commit the next PC, go to S_IDLE.
  - 00: PC unchanged.
  - 01: `PC` <= `BranchTarget` if `BranchSucceed`=1, otherwise unchanged.
  - 10: `PC` <= JumpTarget.
  - 11: `PC` <= {RegA[31:2], 2'b00}. Misaligned low bits are silently cleared.
- `Redirect` pulses for a taken branch, J/JAL, or JR, even if the new PC equals the old one.
- Strobes that do not match the current state are rejected: no state or register change, `SeqError` pulses.
- More than one strobe high in the same cycle is also rejected with a `SeqError` pulse, in any state.
- All additions are 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 = 0; backward branch offsets wrap.

## Timing
- Reset values:
  - `PC` = `RESET_VECTOR`; `InstrAddr` = `RESET_VECTOR`.
  - `BranchTarget` = 0; JumpTarget = 0.
  - `Redirect` = 0; `SeqError` = 0; counters = 0.
- Every strobe takes effect at the posedge where it is sampled high. Outputs are visible one cycle later.
- `Redirect` and `SeqError` are high for exactly the one cycle after the triggering edge.
- `BranchSucceed` is updated by the branch unit on negedge. Control must assert `ResolveEn` at a posedge that follows at least one negedge inside its branch-evaluate state. `pc_unit` does no synchronisation of its own.
- `rst` overrides everything, in any state and even with strobes high. The sequencer returns to S_IDLE with all reset values, abandoning any in-flight instruction.
- Minimum instruction period: 3 cycles (fetch, decode, resolve). Idle cycles between strobes are allowed, and all registers hold during them.

## Configuration
- `BRANCH_STATS_EN` defined:
  - `BranchCount` increments on every accepted resolve with `PCSrc`=01.
  - `TakenCount` increments when such a resolve also has `BranchSucceed`=1.
  - Both counters wrap at 2^32 and are cleared by `rst`.
- Not defined: both ports and their counters are absent. All other behaviour is identical.

## Structure
- The shared package holds:
  - The `PCSrc` encodings: PCSRC_SEQ, PCSRC_BR, PCSRC_J, PCSRC_JR.
  - The state encodings: S_IDLE, S_FETCHED, S_DECODED.
  - The default reset vector constant.
- One sub-module, `pc_target_calc`: purely combinational branch-target and jump-target computation from `PC` and `Instr`. Its outputs are registered in `pc_unit`.

## Test plan
- Reset then fetch: `rst` for 2 cycles, then `FetchEn` → `PC`=32'h3004, `InstrAddr`=32'h3000.
- Taken backward branch: fetch at 32'h3010, decode with `Instr`[15:0]=16'hFFFC, resolve with `PCSrc`=01 and `BranchSucceed`=1 → `PC`=32'h3004, `Redirect` pulses once, `TakenCount`=1.
- Not-taken branch: same sequence with `BranchSucceed`=0 → `PC`=32'h3014, no `Redirect`, `BranchCount`=1 and `TakenCount`=0.
- Jump and JR:
  - `Instr`[25:0]=26'h000_0100 with `PCSrc`=10 → `PC`=32'h0000_0400.
  - `RegA`=32'h0000_3023 with `PCSrc`=11 → `PC`=32'h0000_3020.
- Protocol errors:
  - `DecodeEn` in S_IDLE → `SeqError` pulse, `PC` unchanged.
  - `FetchEn` and `ResolveEn` high together in S_DECODED → `SeqError` pulse, state stays S_DECODED.
- Wrap and mid-operation reset:
  - Fetch at 32'hFFFF_FFFC → `PC`=0.
  - `rst` asserted in S_DECODED with `ResolveEn` high → `PC`=32'h3000, state S_IDLE, counters 0.
